// File: rtl/irq_pkg.sv
// Shared types and constants for the 8-line interrupt pending latch.
package irq_pkg;

  localparam int IRQ_N   = 8;
  localparam int IRQ_IDW = 3;

  typedef logic [IRQ_N-1:0]   irq_vec_t;
  typedef logic [IRQ_IDW-1:0] irq_id_t;

  // One-hot decode of a line index, used to build the per-line clear vector.
  function automatic irq_vec_t irq_onehot(input irq_id_t id);
    irq_vec_t v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_sync_bit.sv
// Parameterized-depth flop synchronizer for one asynchronous request bit.
module irq_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/irq_pending_latch8.sv
// Sticky per-line interrupt pending latch feeding an 8-to-3 priority encoder.
// Optional input synchronizer enabled by defining IRQ_SYNC_EN.
module irq_pending_latch8
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  irq_vec_t irq_in,
  input  irq_vec_t irq_mask,
  input  irq_vec_t edge_mode,
  input  logic     ack,
  input  irq_id_t  ack_id,
  input  logic     ovr_clr,
  output irq_vec_t pend_out,
  output logic     pend_valid,
  output irq_vec_t overrun
);

  irq_vec_t s;
  irq_vec_t prev;
  irq_vec_t pending;
  irq_vec_t ovr_q;
  irq_vec_t set_v;
  irq_vec_t clr_v;

`ifdef IRQ_SYNC_EN
  for (genvar i = 0; i < IRQ_N; i++) begin : g_sync
    irq_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (irq_in[i]),
      .q     (s[i])
    );
  end
`else
  assign s = irq_in;
`endif

  // prev resets to 0, so a line already high at reset release reads as an edge.
  always_comb begin
    set_v = (edge_mode & s & ~prev) | (~edge_mode & s);
    clr_v = ack ? irq_onehot(ack_id) : '0;
  end

  // ack/ack_id: single-cycle pulse, sampled on the rising edge; no backpressure.
  // A set on the same edge as a clear wins, so a held level line re-pends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= '0;
      pending <= '0;
      ovr_q   <= '0;
    end else begin
      prev    <= s;
      pending <= set_v | (pending & ~clr_v);
      ovr_q   <= (ovr_q & {IRQ_N{~ovr_clr}}) | (edge_mode & set_v & pending & ~clr_v);
    end
  end

  // Masking affects only what the encoder sees; masked lines keep latching.
  assign pend_out   = pending & irq_mask;
  assign pend_valid = |pend_out;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_irq_pending_latch8.sv
// Directed bench for irq_pending_latch8 with a per-cycle reference model.
module tb_irq_pending_latch8;

`ifdef IRQ_SYNC_EN
  localparam int SS  = 2;
  localparam int LAT = SS + 1;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_in;
  logic [7:0] irq_mask;
  logic [7:0] edge_mode;
  logic       ack;
  logic [2:0] ack_id;
  logic       ovr_clr;
  logic [7:0] pend_out;
  logic       pend_valid;
  logic [7:0] overrun;

  int total;
  int bad;

  irq_pending_latch8 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .irq_mask   (irq_mask),
    .edge_mode  (edge_mode),
    .ack        (ack),
    .ack_id     (ack_id),
    .ovr_clr    (ovr_clr),
    .pend_out   (pend_out),
    .pend_valid (pend_valid),
    .overrun    (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // reference model: delayed view of irq_in, then the pending/overrun rules per line
  logic [7:0] m_pend;
  logic [7:0] m_ovr;
  logic [7:0] m_prev;
`ifdef IRQ_SYNC_EN
  logic [7:0] hist [SS];
`endif

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] sv;
    logic [7:0] np;
    logic [7:0] no;
    logic       st;
    logic       cl;
    if (!rst_n) begin
      m_pend <= '0;
      m_ovr  <= '0;
      m_prev <= '0;
`ifdef IRQ_SYNC_EN
      for (int i = 0; i < SS; i++) hist[i] <= '0;
`endif
    end else begin
`ifdef IRQ_SYNC_EN
      sv = hist[SS-1];
      for (int i = SS - 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= irq_in;
`else
      sv = irq_in;
`endif
      for (int i = 0; i < 8; i++) begin
        st = edge_mode[i] ? (sv[i] && !m_prev[i]) : sv[i];
        cl = ack && (int'(ack_id) == i);
        no[i] = (m_ovr[i] && !ovr_clr) || (edge_mode[i] && st && m_pend[i] && !cl);
        np[i] = st || (m_pend[i] && !cl);
      end
      m_pend <= np;
      m_ovr  <= no;
      m_prev <= sv;
    end
  end

  // compare process: every falling edge, all outputs against the model
  always @(negedge clk) begin
    total++;
    if (pend_out !== (m_pend & irq_mask)) begin
      bad++;
      $display("FAIL model_pend_out t=%0t got=%h exp=%h", $time, pend_out, m_pend & irq_mask);
    end
    total++;
    if (pend_valid !== (|(m_pend & irq_mask))) begin
      bad++;
      $display("FAIL model_pend_valid t=%0t got=%b exp=%b", $time, pend_valid, |(m_pend & irq_mask));
    end
    total++;
    if (overrun !== m_ovr) begin
      bad++;
      $display("FAIL model_overrun t=%0t got=%h exp=%h", $time, overrun, m_ovr);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic pulse_line(input logic [7:0] v);
    irq_in = v;
    tick(1);
    irq_in = '0;
    tick(LAT + 1);
  endtask

  task automatic do_ack(input logic [2:0] id);
    ack    = 1'b1;
    ack_id = id;
    tick(1);
    ack    = 1'b0;
  endtask

  // scoreboard for the encoder loop
  logic [2:0] exp_q[$];

  initial begin
    logic [2:0] enc;
    int         n;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    irq_in = '0;
    irq_mask = 8'hFF;
    edge_mode = 8'hFF;
    ack = 1'b0;
    ack_id = '0;
    ovr_clr = 1'b0;
    tick(2);
    #1;
    lit("reset_pend_out", pend_out, 8'h00);
    lit("reset_pend_valid", {7'd0, pend_valid}, 8'h00);
    lit("reset_overrun", overrun, 8'h00);
    rst_n = 1'b1;
    tick(2);

    // 1: edge capture and ack
    irq_in = 8'h20;
    tick(1);
    irq_in = '0;
    if (LAT > 1) tick(LAT - 1);
    #1;
    lit("edge_latency", pend_out, 8'h20);
    tick(3);
    #1;
    lit("edge_sticky", pend_out, 8'h20);
    do_ack(3'd5);
    #1;
    lit("edge_ack_pend", pend_out, 8'h00);
    lit("edge_ack_valid", {7'd0, pend_valid}, 8'h00);

    // 2: level re-pend
    edge_mode = 8'h00;
    irq_in = 8'h04;
    tick(LAT);
    #1;
    lit("level_set", pend_out, 8'h04);
    do_ack(3'd2);
    #1;
    lit("level_repend", pend_out, 8'h04);
    irq_in = '0;
    tick(LAT);
    do_ack(3'd2);
    #1;
    lit("level_cleared", pend_out, 8'h00);

    // 3: mask gates output only
    edge_mode = 8'hFF;
    irq_mask = 8'hFE;
    pulse_line(8'h01);
    #1;
    lit("mask_hidden", pend_out, 8'h00);
    lit("mask_hidden_valid", {7'd0, pend_valid}, 8'h00);
    irq_mask = 8'hFF;
    #1;
    lit("mask_reveal", pend_out, 8'h01);
    do_ack(3'd0);

    // 4: overrun
    pulse_line(8'h08);
    pulse_line(8'h08);
    #1;
    lit("ovr_set", overrun, 8'h08);
    lit("ovr_pend_kept", pend_out, 8'h08);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    #1;
    lit("ovr_clr", overrun, 8'h00);
    irq_in = 8'h08;
    if (LAT == 1) begin
      ack = 1'b1;
      ack_id = 3'd3;
    end
    tick(1);
    irq_in = '0;
    ack = 1'b0;
    if (LAT > 2) tick(LAT - 2);
    if (LAT > 1) do_ack(3'd3);
    #1;
    lit("ack_edge_same_pend", pend_out, 8'h08);
    lit("ack_edge_same_ovr", overrun, 8'h00);
    do_ack(3'd3);
    tick(LAT);

    // 5: async reset mid-operation
    pulse_line(8'hA5);
    #1;
    lit("pre_reset_pend", pend_out, 8'hA5);
    #1;
    rst_n = 1'b0;
    #1;
    lit("async_rst_pend", pend_out, 8'h00);
    lit("async_rst_valid", {7'd0, pend_valid}, 8'h00);
    irq_in = 8'h80;
    tick(2);
    rst_n = 1'b1;
    tick(LAT);
    #1;
    lit("release_edge", pend_out, 8'h80);
    irq_in = '0;
    do_ack(3'd7);
    tick(LAT);

    // 6: multi-line and encoder loop
    exp_q.push_back(3'd6);
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd1);
    pulse_line(8'h52);
    #1;
    lit("multi_pend", pend_out, 8'h52);
    n = 0;
    while (pend_valid && n < 8) begin
      enc = '0;
      for (int i = 0; i < 8; i++) if (pend_out[i]) enc = 3'(i);
      if (exp_q.size() == 0) begin
        lit("enc_extra", {5'd0, enc}, 8'hFF);
      end else begin
        lit("enc_order", {5'd0, enc}, {5'd0, exp_q.pop_front()});
      end
      do_ack(enc);
      #1;
      n++;
    end
    lit("enc_count", 8'(n), 8'd3);
    lit("enc_final", pend_out, 8'h00);

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
